// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 content sources: channel indices,
// pattern modes, FSM states and the bit-depth scaling function.
package hub75_pkg;

  localparam int unsigned CH_RED   = 0;
  localparam int unsigned CH_GREEN = 1;
  localparam int unsigned CH_BLUE  = 2;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_HGRAD = 2'd1,
    MODE_VGRAD = 2'd2,
    MODE_XOR   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PIXELS    = 3'd1,
    ST_ROW_STORE = 3'd2,
    ST_ROW_WAIT  = 3'd3,
    ST_SWAP      = 3'd4,
    ST_SWAP_WAIT = 3'd5
  } state_e;

  // Left-align a w-bit value into np bits; result sits in the low np bits.
  function automatic logic [31:0] scale(input logic [31:0] x,
                                        input int unsigned w,
                                        input int unsigned np);
    if (w > np) return x >> (w - np);
    return x << (np - w);
  endfunction

endpackage

// File: rtl/hub75_pattern_gen_if.sv
// Frame buffer write port: pixel stream plus row-commit and swap handshakes.
interface hub75_pattern_gen_if #(
  parameter int unsigned N_ROWS   = 64,
  parameter int unsigned N_COLS   = 64,
  parameter int unsigned N_CHANS  = 3,
  parameter int unsigned N_PLANES = 8
);
  localparam int unsigned LOG_N_ROWS = $clog2(N_ROWS);
  localparam int unsigned LOG_N_COLS = $clog2(N_COLS);

  logic [LOG_N_ROWS-1:0]         wr_row_addr;
  logic [LOG_N_COLS-1:0]         wr_col_addr;
  logic [N_CHANS*N_PLANES-1:0]   wr_data;
  logic                          wr_valid;
  logic                          wr_ready;
  logic                          row_store;
  logic                          row_ready;
  logic                          frame_swap;
  logic                          frame_rdy;

  modport master (
    output wr_row_addr, wr_col_addr, wr_data, wr_valid, row_store, frame_swap,
    input  wr_ready, row_ready, frame_rdy
  );

  modport slave (
    input  wr_row_addr, wr_col_addr, wr_data, wr_valid, row_store, frame_swap,
    output wr_ready, row_ready, frame_rdy
  );
endinterface

// File: rtl/hub75_pattern_pix.sv
// Pixel renderer: registers the colour for (mode, row, col, F) presented as
// next-cycle coordinates, so data lines up with the registered addresses.
module hub75_pattern_pix
  import hub75_pkg::*;
#(
  parameter int unsigned N_ROWS   = 64,
  parameter int unsigned N_COLS   = 64,
  parameter int unsigned N_CHANS  = 3,
  parameter int unsigned N_PLANES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_load,
  input  mode_e                         i_mode,
  input  logic [$clog2(N_ROWS)-1:0]     i_row,
  input  logic [$clog2(N_COLS)-1:0]     i_col,
  input  logic [N_PLANES-1:0]           i_f,
  output logic [N_CHANS*N_PLANES-1:0]   o_data
);
  localparam int unsigned LOG_N_ROWS = $clog2(N_ROWS);
  localparam int unsigned LOG_N_COLS = $clog2(N_COLS);
  localparam int unsigned LOG_N_XOR  = (LOG_N_ROWS > LOG_N_COLS) ? LOG_N_ROWS : LOG_N_COLS;
  localparam int unsigned DW         = N_CHANS * N_PLANES;

  logic [N_PLANES-1:0] w_col_s, w_row_s, w_xor_s;
  logic [N_PLANES-1:0] w_red, w_grn, w_blu;
  logic [DW-1:0]       w_data;
  logic [DW-1:0]       r_data;

  always_comb begin
    w_col_s = N_PLANES'(scale(32'(i_col), LOG_N_COLS, N_PLANES));
    w_row_s = N_PLANES'(scale(32'(i_row), LOG_N_ROWS, N_PLANES));
    w_xor_s = N_PLANES'(scale(32'(i_col) ^ 32'(i_row), LOG_N_XOR, N_PLANES));
    w_red   = '1;
    w_grn   = '1;
    w_blu   = '1;
    case (i_mode)
      MODE_HGRAD: begin w_red = w_col_s; w_grn = w_col_s; w_blu = w_col_s; end
      MODE_VGRAD: begin w_red = w_row_s; w_grn = w_row_s; w_blu = w_row_s; end
      MODE_XOR:   begin w_red = w_col_s ^ i_f; w_grn = w_row_s ^ i_f; w_blu = w_xor_s ^ i_f; end
      default:    ;
    endcase
  end

  // Channels beyond blue replicate blue.
  always_comb begin
    w_data = '0;
    for (int unsigned c = 0; c < N_CHANS; c++) begin
      if (c == CH_RED)        w_data[c*N_PLANES +: N_PLANES] = w_red;
      else if (c == CH_GREEN) w_data[c*N_PLANES +: N_PLANES] = w_grn;
      else                    w_data[c*N_PLANES +: N_PLANES] = w_blu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_data <= '0;
    else        r_data <= i_load ? w_data : '0;
  end

  assign o_data = r_data;
endmodule

// File: rtl/hub75_pattern_gen.sv
// Test-pattern frame producer: streams one frame into the HUB75 back buffer,
// commits each row, then requests a buffer swap and repeats while enabled.
module hub75_pattern_gen
  import hub75_pkg::*;
#(
  parameter int unsigned N_ROWS   = 64,
  parameter int unsigned N_COLS   = 64,
  parameter int unsigned N_CHANS  = 3,
  parameter int unsigned N_PLANES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_mode,
  output logic [15:0]           frame_cnt,
  hub75_pattern_gen_if.master   fb
);
  localparam int unsigned LOG_N_ROWS = $clog2(N_ROWS);
  localparam int unsigned LOG_N_COLS = $clog2(N_COLS);

  state_e                 r_state, w_state_nxt;
  logic [LOG_N_ROWS-1:0]  r_row, w_row_nxt, r_wr_row;
  logic [LOG_N_COLS-1:0]  r_col, w_col_nxt, r_wr_col;
  mode_e                  r_mode, w_mode_nxt;
  logic [N_PLANES-1:0]    r_f, w_f_nxt;
  logic [15:0]            r_frame_cnt, w_frame_cnt_nxt;
  logic                   r_wr_valid, w_wr_valid_nxt;
  logic                   r_row_store, w_row_store_nxt;
  logic                   r_frame_swap, w_frame_swap_nxt;
  logic                   w_xfer, w_last_col, w_last_row;

  assign w_xfer     = r_wr_valid & fb.wr_ready;
  assign w_last_col = (r_col == LOG_N_COLS'(N_COLS - 1));
  assign w_last_row = (r_row == LOG_N_ROWS'(N_ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (cfg_enable) w_state_nxt = ST_PIXELS;
      ST_PIXELS:    if (w_xfer && w_last_col) w_state_nxt = ST_ROW_STORE;
      ST_ROW_STORE: w_state_nxt = ST_ROW_WAIT;
      ST_ROW_WAIT:  if (fb.row_ready) w_state_nxt = w_last_row ? ST_SWAP : ST_PIXELS;
      ST_SWAP:      w_state_nxt = ST_SWAP_WAIT;
      ST_SWAP_WAIT: if (fb.frame_rdy) w_state_nxt = cfg_enable ? ST_PIXELS : ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter and output next values; the pattern seed F is the count at frame start.
  always_comb begin
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_mode_nxt      = r_mode;
    w_f_nxt         = r_f;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      ST_IDLE: if (cfg_enable) begin
        w_mode_nxt = mode_e'(cfg_mode);
        w_row_nxt  = '0;
        w_col_nxt  = '0;
        w_f_nxt    = N_PLANES'(r_frame_cnt);
      end
      ST_PIXELS: if (w_xfer) w_col_nxt = r_col + LOG_N_COLS'(1);
      ST_ROW_WAIT: if (fb.row_ready && !w_last_row) begin
        w_row_nxt = r_row + LOG_N_ROWS'(1);
        w_col_nxt = '0;
      end
      ST_SWAP_WAIT: if (fb.frame_rdy) begin
        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
        if (cfg_enable) begin
          w_mode_nxt = mode_e'(cfg_mode);
          w_row_nxt  = '0;
          w_col_nxt  = '0;
          w_f_nxt    = N_PLANES'(r_frame_cnt + 16'd1);
        end
      end
      default: ;
    endcase
    w_wr_valid_nxt   = (w_state_nxt == ST_PIXELS);
    w_row_store_nxt  = (w_state_nxt == ST_ROW_STORE);
    w_frame_swap_nxt = (w_state_nxt == ST_SWAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row        <= '0;
      r_col        <= '0;
      r_mode       <= MODE_SOLID;
      r_f          <= '0;
      r_frame_cnt  <= '0;
      r_wr_valid   <= 1'b0;
      r_row_store  <= 1'b0;
      r_frame_swap <= 1'b0;
      r_wr_row     <= '0;
      r_wr_col     <= '0;
    end else begin
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_mode       <= w_mode_nxt;
      r_f          <= w_f_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_wr_valid   <= w_wr_valid_nxt;
      r_row_store  <= w_row_store_nxt;
      r_frame_swap <= w_frame_swap_nxt;
      r_wr_row     <= w_wr_valid_nxt ? w_row_nxt : '0;
      r_wr_col     <= w_wr_valid_nxt ? w_col_nxt : '0;
    end
  end

  hub75_pattern_pix #(
    .N_ROWS  (N_ROWS),
    .N_COLS  (N_COLS),
    .N_CHANS (N_CHANS),
    .N_PLANES(N_PLANES)
  ) u_pix (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_wr_valid_nxt),
    .i_mode(w_mode_nxt),
    .i_row (w_row_nxt),
    .i_col (w_col_nxt),
    .i_f   (w_f_nxt),
    .o_data(fb.wr_data)
  );

  assign fb.wr_valid    = r_wr_valid;
  assign fb.wr_row_addr = r_wr_row;
  assign fb.wr_col_addr = r_wr_col;
  assign fb.row_store   = r_row_store;
  assign fb.frame_swap  = r_frame_swap;
  assign frame_cnt      = r_frame_cnt;
endmodule
